// File: rtl/tspi_pkg.sv
// TSPI device-side shared definitions: opcodes, command field widths, FSM states.
// No logic, so it adds no latency and has no backpressure.
package tspi_pkg;

  localparam int unsigned TSPI_OP_BITS   = 8;
  localparam int unsigned TSPI_ADDR_BITS = 24;

  localparam logic [TSPI_OP_BITS-1:0] TSPI_OP_WRITE = 8'h01;
  localparam logic [TSPI_OP_BITS-1:0] TSPI_OP_READ  = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_MEM_REQ,
    ST_WAIT_RVALID,
    ST_RESP,
    ST_TX,
    ST_DRAIN,
    ST_ERR_DRAIN
  } tspi_dev_state_e;

endpackage

// File: rtl/tspi_device_sync.sv
// Synchronizes the TSPI pins into clk_i and flags TSPI clock rise/fall edges.
// Latency is SyncStages cycles from pin to strobe; there is no backpressure.
module tspi_device_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tspi_clk_i,
  input  logic tspi_cs_ni,
  input  logic tspi_mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_n_o,
  output logic mosi_o
);

  logic [SyncStages-1:0] sclk_q, cs_n_q, mosi_q;
  logic                  sclk_prev_q;

  // CS resets to its inactive level so reset never looks like a frame start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q      <= '0;
      cs_n_q      <= '1;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_q[0] <= tspi_clk_i;
      cs_n_q[0] <= tspi_cs_ni;
      mosi_q[0] <= tspi_mosi_i;
      for (int i = 1; i < int'(SyncStages); i++) begin
        sclk_q[i] <= sclk_q[i-1];
        cs_n_q[i] <= cs_n_q[i-1];
        mosi_q[i] <= mosi_q[i-1];
      end
      sclk_prev_q <= sclk_q[SyncStages-1];
    end
  end

  assign sclk_rise_o = sclk_q[SyncStages-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_q[SyncStages-1] & sclk_prev_q;
  assign cs_n_o      = cs_n_q[SyncStages-1];
  assign mosi_o      = mosi_q[SyncStages-1];

endmodule

// File: rtl/tspi_device.sv
// TSPI responder: turns each host frame into one req/gnt/rvalid memory access and serializes the reply.
// Memory stalls are absorbed by holding MISO low; the host keeps clocking until the start/ack bit appears.
module tspi_device
  import tspi_pkg::*;
#(
  parameter int unsigned AddrWidth  = TSPI_ADDR_BITS,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tspi_clk_i,
  input  logic                 tspi_cs_ni,
  input  logic                 tspi_mosi_i,
  output logic                 tspi_miso_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned CmdBits = TSPI_OP_BITS + AddrWidth;
  localparam int unsigned RxWidth = (CmdBits > DataWidth) ? CmdBits : DataWidth;

  logic sclk_rise, sclk_fall, cs_n, mosi;

  tspi_device_sync #(.SyncStages(SyncStages)) u_sync (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tspi_clk_i  (tspi_clk_i),
    .tspi_cs_ni  (tspi_cs_ni),
    .tspi_mosi_i (tspi_mosi_i),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_n_o      (cs_n),
    .mosi_o      (mosi)
  );

  tspi_dev_state_e        state_q, state_d;
  logic [6:0]             cnt_q, cnt_d;
  logic [RxWidth-1:0]     rx_q, rx_d, rx_shift;
  logic [DataWidth-1:0]   tx_q, tx_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   we_q, we_d, req_q, req_d, rd_pend_q, rd_pend_d;
  logic                   miso_q, miso_d, err_q, err_d;
  logic [TSPI_OP_BITS-1:0] opcode;

  assign rx_shift = {rx_q[RxWidth-2:0], mosi};
  assign opcode   = rx_shift[CmdBits-1 -: TSPI_OP_BITS];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    we_d      = we_q;
    req_d     = req_q;
    rd_pend_d = rd_pend_q;
    miso_d    = miso_q;
    err_d     = 1'b0;

    // Handshake tracking is frame-independent so an aborted access still retires cleanly.
    if (req_q && mem_gnt_i) begin
      req_d     = 1'b0;
      rd_pend_d = !we_q && !mem_rvalid_i;
    end else if (rd_pend_q && mem_rvalid_i) begin
      rd_pend_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!cs_n) begin
          cnt_d = '0;
          if (req_q || rd_pend_q) begin
            err_d   = 1'b1;
            state_d = ST_ERR_DRAIN;
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          rx_d  = rx_shift;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'(CmdBits - 1)) begin
            cnt_d  = '0;
            addr_d = rx_shift[AddrWidth-1:0];
            if (opcode == TSPI_OP_WRITE) begin
              we_d    = 1'b1;
              state_d = ST_WDATA;
            end else if (opcode == TSPI_OP_READ) begin
              we_d    = 1'b0;
              req_d   = 1'b1;
              state_d = ST_MEM_REQ;
            end else begin
              err_d   = 1'b1;
              state_d = ST_ERR_DRAIN;
            end
          end
        end
      end
      ST_WDATA: begin
        if (sclk_rise) begin
          rx_d  = rx_shift;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'(DataWidth - 1)) begin
            req_d   = 1'b1;
            state_d = ST_MEM_REQ;
          end
        end
      end
      ST_MEM_REQ: begin
        if (mem_gnt_i) begin
          if (we_q) begin
            state_d = ST_RESP;
          end else if (mem_rvalid_i) begin
            tx_d    = mem_rdata_i;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT_RVALID;
          end
        end
      end
      ST_WAIT_RVALID: begin
        if (mem_rvalid_i) begin
          tx_d    = mem_rdata_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (sclk_fall) begin
          miso_d  = 1'b1;
          cnt_d   = '0;
          state_d = we_q ? ST_DRAIN : ST_TX;
        end
      end
      ST_TX: begin
        if (sclk_fall) begin
          miso_d = tx_q[DataWidth-1];
          tx_d   = tx_q << 1;
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == 7'(DataWidth - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (sclk_fall) miso_d = 1'b0;
      end
      ST_ERR_DRAIN: ;
      default: state_d = ST_IDLE;
    endcase

    // A request that was never presented is not a withdrawal; an issued one keeps running.
    if (cs_n && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      miso_d  = 1'b0;
      if (state_q inside {ST_CMD, ST_WDATA}) req_d = 1'b0;
      if (!(state_q inside {ST_DRAIN, ST_ERR_DRAIN})) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      miso_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      req_q     <= req_d;
      rd_pend_q <= rd_pend_d;
      miso_q    <= miso_d;
      err_q     <= err_d;
    end
  end

  assign tspi_miso_o = miso_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = rx_q[DataWidth-1:0];
  assign busy_o      = ~cs_n;
  assign err_o       = err_q;

endmodule

// File: tb/tb_tspi_device.sv
// Directed bench for tspi_device: host bit-bangs TSPI frames, a small responder plays the memory.
module tb_tspi_device;
  import tspi_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        tspi_clk = 1'b0, tspi_cs_n = 1'b1, tspi_mosi = 1'b0;
  logic        tspi_miso, mem_req, mem_we, busy, err;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = '0;

  always #5 clk = ~clk;

  tspi_device dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tspi_clk_i   (tspi_clk),
    .tspi_cs_ni   (tspi_cs_n),
    .tspi_mosi_i  (tspi_mosi),
    .tspi_miso_o  (tspi_miso),
    .mem_req_o    (mem_req),
    .mem_gnt_i    (mem_gnt),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy),
    .err_o        (err)
  );

  int          half = 2;
  int          gnt_dly = 0, rv_dly = 0;
  logic [31:0] rd_data = '0;
  int          req_cnt = 0, err_cnt = 0, hold_viol = 0, req_wait = 0, rv_timer = 0;
  logic [23:0] req_addr = '0, hold_addr = '0;
  logic        req_we = 1'b0, hold_we = 1'b0;
  logic [31:0] req_wdata = '0, hold_wdata = '0;
  logic        miso_or = 1'b0;
  int          n_cmp = 0, n_err = 0;

  // Memory responder: grant after gnt_dly cycles of request, rvalid rv_dly cycles after a read grant.
  initial begin : responder
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (err) err_cnt++;
      if (rst) begin
        req_wait = 0;
        rv_timer = 0;
      end else begin
        if (rv_timer > 0) begin
          rv_timer--;
          if (rv_timer == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_data;
          end
        end
        if (mem_req) begin
          if (req_wait == 0) begin
            hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
          end else if (mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata) begin
            hold_viol++;
          end
          if (req_wait >= gnt_dly) begin
            mem_gnt = 1'b1;
            req_cnt++;
            req_addr = mem_addr; req_we = mem_we; req_wdata = mem_wdata;
            req_wait = 0;
            if (!mem_we) begin
              if (rv_dly == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_data;
              end else begin
                rv_timer = rv_dly;
              end
            end
          end else begin
            req_wait++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer_bit(input logic mo, output logic mi);
    tspi_mosi = mo;
    repeat (half) @(negedge clk);
    tspi_clk = 1'b1;
    repeat (half) @(negedge clk);
    mi = tspi_miso;
    tspi_clk = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    logic b;
    for (int i = 31; i > 31 - nbits; i--) begin
      xfer_bit(w[i], b);
      miso_or = miso_or | b;
    end
  endtask

  task automatic get_start(output logic found);
    logic b;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      xfer_bit(1'b0, b);
      if (b) found = 1'b1;
    end
  endtask

  task automatic get_word(output logic [31:0] w);
    logic b;
    w = '0;
    for (int i = 31; i >= 0; i--) begin
      xfer_bit(1'b0, b);
      w[i] = b;
    end
  endtask

  task automatic cs_low();
    tspi_cs_n = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (half) @(negedge clk);
    tspi_cs_n = 1'b1;
    repeat (half + 4) @(negedge clk);
  endtask

  initial begin : main
    logic        found, b;
    logic [31:0] w;
    int          e0, r0;
    int          hs[4] = '{2, 3, 5, 8};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_miso", tspi_miso, 0);
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write 0xDEADBEEF to 0x10, immediate grant
    gnt_dly = 0;
    cs_low();
    send_word({8'h01, 24'h000010}, 32);
    send_word(32'hDEADBEEF, 32);
    get_start(found);
    check("wr_ack", found, 1);
    xfer_bit(1'b0, b);
    check("wr_ack_len", b, 0);
    cs_high();
    check("wr_req_cnt", req_cnt, 1);
    check("wr_addr", req_addr, 32'h10);
    check("wr_we", req_we, 1);
    check("wr_wdata", req_wdata, 32'hDEADBEEF);
    check("wr_err", err_cnt, 0);

    // Read 0x10, grant +3, rvalid +5
    gnt_dly = 3; rv_dly = 5; rd_data = 32'hDEADBEEF;
    cs_low();
    send_word({8'h02, 24'h000010}, 32);
    get_start(found);
    get_word(w);
    cs_high();
    check("rd_start", found, 1);
    check("rd_data", w, 32'hDEADBEEF);
    check("rd_req_cnt", req_cnt, 2);
    check("rd_we", req_we, 0);
    check("rd_addr", req_addr, 32'h10);
    check("rd_err", err_cnt, 0);

    // Illegal opcode 0x7F
    e0 = err_cnt; r0 = req_cnt; miso_or = 1'b0;
    cs_low();
    send_word({8'h7F, 24'h000010}, 32);
    send_word(32'hFFFFFFFF, 32);
    cs_high();
    check("ill_err", err_cnt - e0, 1);
    check("ill_noreq", req_cnt - r0, 0);
    check("ill_miso", miso_or, 0);

    // CS abort after 20 command bits, then a normal write
    e0 = err_cnt; r0 = req_cnt;
    cs_low();
    send_word({8'h01, 24'h000020}, 20);
    cs_high();
    check("abt_err", err_cnt - e0, 1);
    check("abt_noreq", req_cnt - r0, 0);
    check("abt_busy", busy, 0);
    check("abt_state", 32'(dut.state_q), 32'(ST_IDLE));
    gnt_dly = 1;
    cs_low();
    send_word({8'h01, 24'h000020}, 32);
    send_word(32'h12345678, 32);
    get_start(found);
    cs_high();
    check("abt_next_ack", found, 1);
    check("abt_next_wdata", req_wdata, 32'h12345678);
    check("abt_next_addr", req_addr, 32'h20);

    // CS abort during read wait with grant stalled; follow-on frame while pending is ignored
    e0 = err_cnt; r0 = req_cnt; miso_or = 1'b0;
    gnt_dly = 30; rv_dly = 4; rd_data = 32'h11111111;
    cs_low();
    send_word({8'h02, 24'h000040}, 32);
    send_word(32'h0, 2);
    cs_high();
    check("rdabt_err", err_cnt - e0, 1);
    check("rdabt_req_held", mem_req, 1);
    check("rdabt_miso", tspi_miso, 0);
    cs_low();
    send_word({8'h01, 24'h000050}, 12);
    cs_high();
    check("pend_frame_err", err_cnt - e0, 2);
    repeat (20) @(negedge clk);
    check("rdabt_req_drop", mem_req, 0);
    check("rdabt_one_req", req_cnt - r0, 1);
    check("rdabt_addr", req_addr, 32'h40);
    check("rdabt_miso_all", miso_or, 0);
    gnt_dly = 3; rv_dly = 5; rd_data = 32'h5A5A0FF0;
    cs_low();
    send_word({8'h02, 24'h000041}, 32);
    get_start(found);
    get_word(w);
    cs_high();
    check("rdabt_next_data", w, 32'h5A5A0FF0);
    check("rdabt_next_err", err_cnt - e0, 2);

    // Reset in the middle of TX
    gnt_dly = 0; rv_dly = 1; rd_data = 32'hDEADBEEF;
    cs_low();
    send_word({8'h02, 24'h000010}, 32);
    get_start(found);
    for (int i = 0; i < 8; i++) xfer_bit(1'b0, b);
    @(negedge clk);
    rst = 1'b1; tspi_cs_n = 1'b1;
    @(negedge clk);
    check("rtx_miso", tspi_miso, 0);
    check("rtx_req", mem_req, 0);
    check("rtx_busy", busy, 0);
    check("rtx_err", err, 0);
    check("rtx_addr", mem_addr, 0);
    check("rtx_wdata", mem_wdata, 0);
    check("rtx_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Clock-ratio sweep 4x..16x, including grant and rvalid in the same cycle
    for (int k = 0; k < 4; k++) begin
      half = hs[k];
      e0 = err_cnt;
      gnt_dly = (k == 1) ? 0 : 2;
      rv_dly  = (k == 1) ? 0 : 3;
      rd_data = 32'h3C96A50F;
      cs_low();
      send_word({8'h02, 24'h000100 + 24'(k)}, 32);
      get_start(found);
      get_word(w);
      cs_high();
      check($sformatf("sweep%0d_start", k), found, 1);
      check($sformatf("sweep%0d_data", k), w, 32'h3C96A50F);
      check($sformatf("sweep%0d_addr", k), req_addr, 32'h100 + k);
      check($sformatf("sweep%0d_err", k), err_cnt - e0, 0);
    end

    check("req_hold_stable", hold_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
